// File: rtl/srt_mul_rebuild.sv
// rtl/srt_mul_rebuild.sv - sequential radix-2 shift-add multiply-accumulate, P = A*B + C
// Rebuilds a dividend from {quotient, divisor, remainder}; one multiplier bit per cycle.
module srt_mul_rebuild #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     C,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CW-1:0]      r_cnt;
  logic               w_accept;
  logic               w_last;
  logic [2*WIDTH-1:0] w_sum;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_sum    = r_acc + (r_b[0] ? r_a : '0);
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The last RUN step folds straight into P so the result lands on the done edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      P     <= '0;
    end else if (w_accept) begin
      r_acc <= {{WIDTH{1'b0}}, C};
      r_a   <= {{WIDTH{1'b0}}, A};
      r_b   <= B;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_sum;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        P <= w_sum;
      end
    end
  end

endmodule

// File: tb/tb_srt_mul_rebuild.sv
// tb/tb_srt_mul_rebuild.sv - scoreboard bench for srt_mul_rebuild
module tb_srt_mul_rebuild;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [W-1:0]   C = '0;
  logic [2*W-1:0] P;
  logic           busy;
  logic           done;

  typedef struct {
    logic [2*W-1:0] p;
    int             cyc;
  } exp_t;

  exp_t           sb[$];
  int             cyc = 0;
  int             n_checks = 0;
  int             n_fails = 0;
  logic [2*W-1:0] model_p = '0;
  logic           mon_en = 1'b0;

  srt_mul_rebuild #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .C     (C),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        check_eq("done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("p_result", P, e.p);
          check_eq("done_cycle", cyc, e.cyc);
          check_eq("busy_on_done", busy, 0);
          model_p = e.p;
        end
      end else begin
        check_eq("p_hold", P, model_p);
      end
    end
  end

  // Call right after a negedge with the DUT able to accept; returns at the accept negedge.
  task automatic do_op(input int a, input int b, input int c);
    A = W'(a);
    B = W'(b);
    C = W'(c);
    start = 1'b1;
    @(negedge clk);
    sb.push_back('{p: (2*W)'(a * b + c), cyc: cyc + W});
    check_eq("busy_after_start", busy, 1);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    check_eq("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  int ta[7] = '{5, 4, 6, 4, 255, 0, 77};
  int tb[7] = '{5, 6, 19, 52, 255, 1, 0};
  int tc[7] = '{0, 1, 0, 47, 255, 0, 9};
  int ba[3] = '{12, 250, 3};
  int bb[3] = '{34, 7, 200};
  int bc[3] = '{5, 255, 0};

  initial begin
    repeat (2) @(negedge clk);
    check_eq("reset_p", P, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // busy spans W cycles, then P is held
    do_op(5, 5, 0);
    for (int i = 0; i < W - 1; i++) begin
      @(negedge clk);
      check_eq("busy_run", busy, 1);
    end
    drain();
    repeat (3) @(negedge clk);
    check_eq("p_held", P, 25);

    for (int i = 1; i < 7; i++) begin
      do_op(ta[i], tb[i], tc[i]);
      drain();
    end

    for (int i = 0; i < 6; i++) begin
      do_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      drain();
    end

    // starts during RUN are ignored
    do_op(200, 3, 7);
    @(negedge clk);
    A = 8'd9; B = 8'd9; C = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    A = 8'd1; B = 8'd2; C = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // reset mid-operation aborts without a done pulse
    do_op(100, 100, 100);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    model_p = '0;
    sb.delete();
    @(negedge clk);
    check_eq("abort_p", P, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    do_op(13, 11, 2);
    drain();

    // back-to-back with start held high
    A = W'(ba[0]); B = W'(bb[0]); C = W'(bc[0]); start = 1'b1;
    @(negedge clk);
    sb.push_back('{p: (2*W)'(ba[0] * bb[0] + bc[0]), cyc: cyc + W});
    for (int i = 1; i < 3; i++) begin
      for (int t = 0; t < 20 && !done; t++) @(negedge clk);
      check_eq("b2b_done_seen", done, 1);
      A = W'(ba[i]); B = W'(bb[i]); C = W'(bc[i]);
      @(negedge clk);
      sb.push_back('{p: (2*W)'(ba[i] * bb[i] + bc[i]), cyc: cyc + W});
      check_eq("b2b_busy", busy, 1);
    end
    start = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
